// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request payload, FSM states, wait-state counter width.
package dmem_responder_pkg;

  localparam int DMEM_LAT_W = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous data array: per-byte write enable, registered read.
module dmem_array #(
  parameter int    ADDR_WIDTH = 10,
  parameter int    DATA_WIDTH = 32,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // contents survive a reset of the surrounding logic.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one outstanding load/store, LATENCY wait states, single-cycle response pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter int    DATA_WIDTH = 32,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int                    LAT_M1_INT = (LATENCY == 0) ? 0 : LATENCY - 1;
  localparam logic [DMEM_LAT_W-1:0] LAT_M1     = LAT_M1_INT[DMEM_LAT_W-1:0];

  dmem_state_t           state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  dmem_req_t             req_q, req_d, in_req, acc_req;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic                  load_q, load_d;
  logic                  access, acc_err;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign in_req = '{we: we_i, addr: addr_i, be: be_i, wdata: wdata_i};

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    load_d   = load_q;
    access   = 1'b0;
    acc_req  = req_q;
    gnt_o    = rst && req_i && (state_q != DM_WAIT);

    case (state_q)
      DM_IDLE, DM_RESP: begin
        if (gnt_o) begin
          req_d = in_req;
          if (LATENCY == 0) begin
            // Zero wait states: the array sees the live payload on the accept edge.
            access  = 1'b1;
            acc_req = in_req;
            state_d = DM_RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = DM_WAIT;
          end
        end else begin
          state_d = DM_IDLE;
        end
      end
      DM_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = DM_RESP;
        end
      end
      default: state_d = DM_IDLE;
    endcase

    acc_err = (acc_req.addr[31:ADDR_WIDTH+2] != '0) || (acc_req.be == '0);
    if (access) begin
      rvalid_d = 1'b1;
      err_d    = acc_err;
      load_d   = !acc_req.we && !acc_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DM_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      load_q   <= load_d;
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .en_i   (access && !acc_err),
    .we_i   (acc_req.we),
    .addr_i (acc_req.addr[ADDR_WIDTH+1:2]),
    .be_i   (acc_req.be),
    .wdata_i(acc_req.wdata),
    .rdata_o(arr_rdata)
  );

  // The array read register holds its last load; load_q masks it for stores, errors and reset.
  assign rdata_o  = load_q ? arr_rdata : '0;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != DM_IDLE);

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^acc_req.addr[1:0];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: four responders (LATENCY 0, 3, 1, 5) exercised through a shared request task.
module tb_dmem_responder;

  logic             clk = 1'b0;
  logic [3:0]       rst = '0;
  logic [3:0]       req = '0;
  logic [3:0]       we  = '0;
  logic [3:0][31:0] addr  = '0;
  logic [3:0][3:0]  be    = '0;
  logic [3:0][31:0] wdata = '0;
  logic [3:0]       gnt, rvalid, err, busy;
  logic [3:0][31:0] rdata;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  // Instance 0: LATENCY 0, 1: LATENCY 3, 2: LATENCY 1, 3: LATENCY 5.
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 1 : 5;
      dmem_responder #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .LATENCY   (LAT),
        .INIT_FILE ("")
      ) u_dut (
        .clk     (clk),
        .rst     (rst[g]),
        .req_i   (req[g]),
        .we_i    (we[g]),
        .addr_i  (addr[g]),
        .be_i    (be[g]),
        .wdata_i (wdata[g]),
        .gnt_o   (gnt[g]),
        .rvalid_o(rvalid[g]),
        .rdata_o (rdata[g]),
        .err_o   (err[g]),
        .busy_o  (busy[g])
      );
    end
  endgenerate

  // One complete transaction; lat = cycles from accept edge to the rvalid cycle, gw = cycles waited for gnt.
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output int gw);
    bit g = 0;
    rd  = 'x;
    er  = 1'bx;
    lat = -1;
    gw  = 0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    while (!g && gw < 20) begin
      #1;
      if (gnt[d]) g = 1;
      else begin
        gw++;
        @(negedge clk);
      end
    end
    if (!g) begin
      n_chk++;
      $display("FAIL xact_grant dut%0d addr=%h: no gnt_o within 20 cycles", d, a);
      req[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0;
    lat = 1;
    while (!rvalid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (rvalid[d]) begin
      rd = rdata[d];
      er = err[d];
    end else begin
      lat = -1;
    end
  endtask

  task automatic test_reset();
    req = '1; be = '1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      n_chk++;
      if ({gnt[d], rvalid[d], err[d], busy[d], rdata[d]} !== 36'h0)
        $display("FAIL reset_outputs dut%0d: gnt=%b rvalid=%b err=%b busy=%b rdata=%h, want all 0",
                 d, gnt[d], rvalid[d], err[d], busy[d], rdata[d]);
      else n_pass++;
    end
    @(negedge clk);
    req = '0;
    rst = '1;
    @(negedge clk);
  endtask

  task automatic test_lat0_load();
    logic [31:0] rd; logic er; int lat, gw;
    xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat, gw);
    n_chk++;
    if ({er, rd} !== 33'h0) $display("FAIL lat0_store_resp: err=%b rdata=%h, want 0/00000000", er, rd);
    else n_pass++;
    xact(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat, gw);
    n_chk++;
    if (gw !== 0) $display("FAIL lat0_gnt_same_cycle: waited %0d cycles, want 0", gw);
    else n_pass++;
    n_chk++;
    if (lat !== 1) $display("FAIL lat0_latency: %0d cycles, want 1", lat);
    else n_pass++;
    n_chk++;
    if ({er, rd} !== {1'b0, 32'hDEADBEEF}) $display("FAIL lat0_load_resp: err=%b rdata=%h, want 0/deadbeef", er, rd);
    else n_pass++;
  endtask

  task automatic test_lat3_partial_store();
    logic [31:0] rd; logic er; int lat, gw;
    xact(1, 1'b1, 32'h20, 4'hF, 32'hAABBCCDD, rd, er, lat, gw);
    xact(1, 1'b0, 32'h20, 4'hF, 32'h0, rd, er, lat, gw);
    n_chk++;
    if ({er, rd} !== {1'b0, 32'hAABBCCDD}) $display("FAIL lat3_preload: err=%b rdata=%h, want 0/aabbccdd", er, rd);
    else n_pass++;
    xact(1, 1'b1, 32'h20, 4'b0110, 32'h11223344, rd, er, lat, gw);
    n_chk++;
    if (lat !== 4) $display("FAIL lat3_store_latency: %0d cycles, want 4", lat);
    else n_pass++;
    n_chk++;
    if ({er, rd} !== 33'h0) $display("FAIL lat3_store_resp: err=%b rdata=%h, want 0/00000000", er, rd);
    else n_pass++;
    xact(1, 1'b0, 32'h20, 4'b0001, 32'h0, rd, er, lat, gw);
    n_chk++;
    if (lat !== 4) $display("FAIL lat3_load_latency: %0d cycles, want 4", lat);
    else n_pass++;
    n_chk++;
    if ({er, rd} !== {1'b0, 32'hAA2233DD}) $display("FAIL lat3_merged_word: err=%b rdata=%h, want 0/aa2233dd", er, rd);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, gw;
    xact(0, 1'b0, 32'h1000, 4'hF, 32'h0, rd, er, lat, gw);
    n_chk++;
    if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL err_out_of_range: err=%b rdata=%h, want 1/00000000", er, rd);
    else n_pass++;
    n_chk++;
    if (lat !== 1) $display("FAIL err_latency: %0d cycles, want 1", lat);
    else n_pass++;
    xact(0, 1'b1, 32'h14, 4'hF, 32'h55667788, rd, er, lat, gw);
    xact(0, 1'b1, 32'h14, 4'h0, 32'hFFFFFFFF, rd, er, lat, gw);
    n_chk++;
    if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL err_be_zero: err=%b rdata=%h, want 1/00000000", er, rd);
    else n_pass++;
    xact(0, 1'b1, 32'h8000_0014, 4'hF, 32'hFFFFFFFF, rd, er, lat, gw);
    n_chk++;
    if (er !== 1'b1) $display("FAIL err_high_addr_store: err=%b, want 1", er);
    else n_pass++;
    xact(0, 1'b0, 32'h17, 4'hF, 32'h0, rd, er, lat, gw);
    n_chk++;
    if ({er, rd} !== {1'b0, 32'h55667788}) $display("FAIL err_array_untouched: err=%b rdata=%h, want 0/55667788", er, rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, gw;
    int gcyc[$];
    int rcyc[$];
    logic [31:0] rq[$];
    int n = 0;
    for (int i = 0; i < 4; i++) xact(2, 1'b1, 32'h40 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), rd, er, lat, gw);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h40;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (rvalid[2]) begin
        rcyc.push_back(c);
        rq.push_back(rdata[2]);
      end
      if (gnt[2] && req[2]) begin
        gcyc.push_back(c);
        n++;
      end
      @(negedge clk);
      if (n == 4) req[2] = 1'b0;
      else addr[2] = 32'h40 + 32'(4*n);
    end
    n_chk++;
    if (gcyc.size() !== 4) $display("FAIL b2b_grant_count: %0d grants, want 4", gcyc.size());
    else n_pass++;
    n_chk++;
    if (rcyc.size() !== 4) $display("FAIL b2b_rvalid_count: %0d pulses, want 4", rcyc.size());
    else n_pass++;
    if (gcyc.size() == 4 && rcyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (gcyc[i] !== 2*i) $display("FAIL b2b_grant_cycle[%0d]: cycle %0d, want %0d", i, gcyc[i], 2*i);
        else n_pass++;
        n_chk++;
        if (rcyc[i] !== 2*i + 2) $display("FAIL b2b_rvalid_cycle[%0d]: cycle %0d, want %0d", i, rcyc[i], 2*i + 2);
        else n_pass++;
        n_chk++;
        if (rq[i] !== 32'hA000_0000 + 32'(i))
          $display("FAIL b2b_rdata[%0d]: %h, want %h", i, rq[i], 32'hA000_0000 + 32'(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_wait_pulse();
    logic [31:0] rd; logic er; int lat, gw;
    int  k = 1;
    bit  got = 0;
    logic rv_at_g = 1'b0;
    xact(3, 1'b1, 32'h30, 4'hF, 32'h0BADF00D, rd, er, lat, gw);
    @(negedge clk);
    req[3] = 1'b1; we[3] = 1'b0; addr[3] = 32'h30; be[3] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req[3] = 1'b0;
    while (!got && k <= 12) begin
      req[3] = (k == 2) || (k >= 4);
      #1;
      if (k == 2) begin
        n_chk++;
        if ({gnt[3], busy[3]} !== 2'b01) $display("FAIL wait_pulse_no_gnt: gnt=%b busy=%b, want 0/1", gnt[3], busy[3]);
        else n_pass++;
      end
      if (req[3] && gnt[3]) begin
        got = 1;
        rv_at_g = rvalid[3];
      end else begin
        k++;
        @(negedge clk);
      end
    end
    n_chk++;
    if (k !== 6) $display("FAIL wait_pulse_gnt_cycle: granted in cycle %0d after accept, want 6", k);
    else n_pass++;
    n_chk++;
    if (rv_at_g !== 1'b1) $display("FAIL wait_pulse_gnt_in_resp: rvalid=%b at grant, want 1", rv_at_g);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    req[3] = 1'b0;
    lat = 1;
    while (!rvalid[3] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat !== 6 || rdata[3] !== 32'h0BADF00D)
      $display("FAIL wait_pulse_second_resp: latency %0d rdata=%h, want 6/0badf00d", lat, rdata[3]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat, gw;
    int rv_seen = 0;
    @(negedge clk);
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h30; be[3] = 4'hF; wdata[3] = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    req[3] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_chk++;
    if (busy[3] !== 1'b1) $display("FAIL rst_mid_busy_before: busy=%b, want 1", busy[3]);
    else n_pass++;
    rst[3] = 1'b0;
    req[3] = 1'b1;
    #1;
    n_chk++;
    if ({gnt[3], rvalid[3], err[3], busy[3], rdata[3]} !== 36'h0)
      $display("FAIL rst_mid_outputs: gnt=%b rvalid=%b err=%b busy=%b rdata=%h, want all 0",
               gnt[3], rvalid[3], err[3], busy[3], rdata[3]);
    else n_pass++;
    repeat (2) @(negedge clk);
    req[3] = 1'b0;
    rst[3] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rvalid[3]) rv_seen++;
    end
    n_chk++;
    if (rv_seen !== 0) $display("FAIL rst_mid_no_resp: %0d rvalid cycles, want 0", rv_seen);
    else n_pass++;
    xact(3, 1'b0, 32'h30, 4'hF, 32'h0, rd, er, lat, gw);
    n_chk++;
    if ({er, rd} !== {1'b0, 32'h0BADF00D} || lat !== 6)
      $display("FAIL rst_mid_array_intact: err=%b rdata=%h latency %0d, want 0/0badf00d/6", er, rd, lat);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lat0_load();
    test_lat3_partial_store();
    test_errors();
    test_back_to_back();
    test_wait_pulse();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
